// File: rtl/heap_sort_ctrl_if.sv
// Handshake bundle between the heap-sort controller, the key source and the consumer.
interface heap_sort_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             busy;
   logic [3:0]       count;

   modport master (
      output in_valid, in_data, flush, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy, count
   );

   modport slave (
      input  in_valid, in_data, flush, out_ready,
      output in_ready, out_valid, out_data, out_last, busy, count
   );
endinterface

// File: rtl/heap_sort_ctrl.sv
// Heap-sort sequencing controller: loads a batch of signed keys, heapifies them
// in place and drains them in ascending order, re-sifting the root after each pop.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | empty, waiting for the first key of a batch
// S_LOAD  | accepting keys until DEPTH is reached or flush closes batch
// S_BUILD | bottom-up heapify, node bidx sifting down from pos, 1 level/cycle
// S_SIFT  | root sifting down after a pop, 1 level/cycle
// S_DRAIN | presenting the heap root to the consumer
module heap_sort_ctrl #(
   parameter int DEPTH = 6,
   parameter int WIDTH = 32
) (
   input logic             system1000,
   input logic             system1000_rstn,
   heap_sort_ctrl_if.slave hs
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_BUILD,
      S_SIFT,
      S_DRAIN
   } state_t;

   localparam logic [3:0] DEPTH_C = 4'(DEPTH);

   state_t                  state_q, state_d;
   // Sized to the full 4-bit index range so every index is in bounds; slots
   // at or above DEPTH are never written and stay constant.
   logic signed [WIDTH-1:0] heap_q [16];
   logic signed [WIDTH-1:0] heap_d [16];
   logic [3:0]              count_q, count_d;
   logic [3:0]              bidx_q, bidx_d;
   logic [3:0]              pos_q, pos_d;
   logic                    en_q;

   logic       in_ready;
   logic       accept;
   logic [3:0] n_acc;
   logic [4:0] l5, r5;
   logic [3:0] l4, r4, c4;
   logic       has_l, has_r, swap, c_leaf, lvl_done;

   // One sift level at pos: pick the smaller child (left on ties) and decide the swap.
   // Finishing on a swap into a leaf saves the cycle that would only rediscover the leaf.
   assign l5       = {pos_q, 1'b1};
   assign r5       = l5 + 5'd1;
   assign l4       = l5[3:0];
   assign r4       = r5[3:0];
   assign has_l    = l5 < {1'b0, count_q};
   assign has_r    = r5 < {1'b0, count_q};
   assign c4       = (has_r && (heap_q[r4] < heap_q[l4])) ? r4 : l4;
   assign swap     = has_l && (heap_q[c4] < heap_q[pos_q]);
   assign c_leaf   = {c4, 1'b1} >= {1'b0, count_q};
   assign lvl_done = !swap || c_leaf;

   // en_q holds in_ready low until the first edge after reset releases.
   assign in_ready     = en_q && ((state_q == S_IDLE) ||
                                  ((state_q == S_LOAD) && (count_q < DEPTH_C)));
   assign accept       = hs.in_valid && in_ready;
   assign n_acc        = count_q + {3'b000, accept};

   assign hs.in_ready  = in_ready;
   assign hs.out_valid = (state_q == S_DRAIN);
   assign hs.out_last  = (state_q == S_DRAIN) && (count_q == 4'd1);
   assign hs.out_data  = heap_q[0];
   assign hs.busy      = (state_q != S_IDLE);
   assign hs.count     = count_q;

   // Next-state and heap update for the phase sequencer.
   always_comb begin
      state_d = state_q;
      heap_d  = heap_q;
      count_d = count_q;
      bidx_d  = bidx_q;
      pos_d   = pos_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               heap_d[0] = hs.in_data;
               count_d   = 4'd1;
               state_d   = S_LOAD;
            end
         end
         S_LOAD: begin
            if (accept) begin
               heap_d[count_q] = hs.in_data;
               count_d         = n_acc;
            end
            if ((n_acc == DEPTH_C) || hs.flush) begin
               if (n_acc == 4'd1) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_BUILD;
                  bidx_d  = (n_acc >> 1) - 4'd1;
                  pos_d   = (n_acc >> 1) - 4'd1;
               end
            end
         end
         S_BUILD, S_SIFT: begin
            if (swap) begin
               heap_d[pos_q] = heap_q[c4];
               heap_d[c4]    = heap_q[pos_q];
            end
            if (!lvl_done) begin
               pos_d = c4;
            end else if ((state_q == S_SIFT) || (bidx_q == 4'd0)) begin
               state_d = S_DRAIN;
            end else begin
               bidx_d = bidx_q - 4'd1;
               pos_d  = bidx_q - 4'd1;
            end
         end
         S_DRAIN: begin
            if (hs.out_ready) begin
               if (count_q == 4'd1) begin
                  count_d = 4'd0;
                  state_d = S_IDLE;
               end else begin
                  heap_d[0] = heap_q[count_q - 4'd1];
                  count_d   = count_q - 4'd1;
                  pos_d     = 4'd0;
                  state_d   = S_SIFT;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, heap and index registers with synchronous active-low reset.
   always_ff @(posedge system1000) begin
      if (!system1000_rstn) begin
         state_q <= S_IDLE;
         count_q <= '0;
         bidx_q  <= '0;
         pos_q   <= '0;
         en_q    <= 1'b0;
         for (int i = 0; i < 16; i++) heap_q[i] <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         bidx_q  <= bidx_d;
         pos_q   <= pos_d;
         en_q    <= 1'b1;
         heap_q  <= heap_d;
      end
   end

endmodule

// File: tb/tb_heap_sort_ctrl.sv
// Directed and randomized checks for heap_sort_ctrl with DEPTH=6, WIDTH=32.
module tb_heap_sort_ctrl;
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   heap_sort_ctrl_if #(.WIDTH(32)) hs ();

   heap_sort_ctrl #(.DEPTH(6), .WIDTH(32)) dut (
      .system1000      (clk),
      .system1000_rstn (rstn),
      .hs              (hs)
   );

   always #5 clk = ~clk;

   logic [31:0] kv [6];
   logic [31:0] es [6];
   logic [31:0] got_q [$];
   logic        last_q [$];
   int          cnt_q [$];
   int          first_lat;
   bit          tmo, unstable, pop_bad, ready_bad;

   initial begin
      #950000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Offers kv[0..n-1]. fmode 0: flush with last key, 1: flush alone after, 2: none.
   // Returns at the falling edge right after the batch-closing edge.
   task automatic load_batch(input int n, input int fmode, input bit gaps);
      ready_bad = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
               hs.in_valid = 1'b0;
               hs.flush    = 1'b0;
               @(negedge clk);
            end
         end
         hs.in_valid = 1'b1;
         hs.in_data  = kv[i];
         hs.flush    = (fmode == 0) && (i == n - 1);
         if (hs.in_ready !== 1'b1) ready_bad = 1'b1;
         @(negedge clk);
      end
      hs.in_valid = 1'b0;
      hs.flush    = 1'b0;
      if (fmode == 1) begin
         hs.flush = 1'b1;
         @(negedge clk);
         hs.flush = 1'b0;
      end
   endtask

   // Captures n_pop outputs of an n_tot batch; stall holds ready low on the first key.
   task automatic drain(input int n_tot, input int n_pop, input int stall, input bit rnd);
      logic [31:0] rec;
      logic        recl;
      logic        rdy;
      int          st, lat, hb;
      tmo = 1'b0; unstable = 1'b0; pop_bad = 1'b0;
      got_q.delete(); last_q.delete(); cnt_q.delete();
      first_lat = 0;
      while (hs.out_valid !== 1'b1 && first_lat < 40) begin
         @(negedge clk);
         first_lat++;
      end
      if (hs.out_valid !== 1'b1) begin
         tmo = 1'b1;
         return;
      end
      for (int i = 0; i < n_pop; i++) begin
         rec  = hs.out_data;
         recl = hs.out_last;
         got_q.push_back(rec);
         last_q.push_back(recl);
         cnt_q.push_back(int'(hs.count));
         st = (i == 0) ? stall : 0;
         forever begin
            rdy = (st > 0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            if (st > 0) st--;
            hs.out_ready = rdy;
            @(negedge clk);
            if (rdy) break;
            if (hs.out_valid !== 1'b1 || hs.out_data !== rec || hs.out_last !== recl)
               unstable = 1'b1;
         end
         hs.out_ready = 1'b0;
         if (i < n_pop - 1) begin
            hb  = $clog2(n_tot - i) ;
            lat = 0;
            while (hs.out_valid !== 1'b1 && lat < 40) begin
               @(negedge clk);
               lat++;
            end
            if (hs.out_valid !== 1'b1) begin
               tmo = 1'b1;
               return;
            end
            if (lat < 1 || lat > hb) pop_bad = 1'b1;
         end
      end
   endtask

   task automatic make_expected(input int n);
      logic [31:0] t;
      for (int i = 0; i < n; i++) es[i] = kv[i];
      for (int i = 1; i < n; i++)
         for (int j = i; j > 0 && $signed(es[j]) < $signed(es[j-1]); j--) begin
            t = es[j]; es[j] = es[j-1]; es[j-1] = t;
         end
   endtask

   task automatic test_reset;
      hs.in_valid = 1'b0; hs.in_data = '0; hs.flush = 1'b0; hs.out_ready = 1'b0;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (hs.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", hs.in_ready); end
      n_cmp++; if (hs.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", hs.out_valid); end
      n_cmp++; if (hs.out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last: got %b want 0", hs.out_last); end
      n_cmp++; if (hs.out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", hs.out_data); end
      n_cmp++; if (hs.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", hs.busy); end
      n_cmp++; if (hs.count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", hs.count); end
      rstn = 1'b1;
      @(negedge clk);
      n_cmp++; if (hs.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_rise: got %b want 1", hs.in_ready); end
   endtask

   task automatic test_full_batch;
      kv[0] = 5; kv[1] = -3; kv[2] = 17; kv[3] = 0; kv[4] = -3; kv[5] = 9;
      es[0] = -3; es[1] = -3; es[2] = 0; es[3] = 5; es[4] = 9; es[5] = 17;
      load_batch(6, 2, 1'b0);
      n_cmp++; if (ready_bad) begin n_err++; $display("FAIL full_accept: in_ready low during load, want 1"); end
      n_cmp++; if (hs.in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_drop: got %b want 0", hs.in_ready); end
      n_cmp++; if (hs.count !== 4'd6) begin n_err++; $display("FAIL full_count: got %0d want 6", hs.count); end
      n_cmp++; if (hs.busy !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b want 1", hs.busy); end
      drain(6, 6, 0, 1'b0);
      n_cmp++; if (tmo) begin n_err++; $display("FAIL full_timeout: output stalled, got %0d keys want 6", got_q.size()); end
      n_cmp++; if (first_lat > 12) begin n_err++; $display("FAIL full_build_lat: got %0d want <=12", first_lat); end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (i >= got_q.size() || got_q[i] !== es[i] || last_q[i] !== (i == 5) || cnt_q[i] != 6 - i) begin
            n_err++;
            $display("FAIL full_out[%0d]: got %0d last %b cnt %0d want %0d last %b cnt %0d",
                     i, $signed(got_q[i]), last_q[i], cnt_q[i], $signed(es[i]), (i == 5), 6 - i);
         end
      end
      n_cmp++; if (pop_bad) begin n_err++; $display("FAIL full_pop_lat: pop latency outside 1..bound"); end
      n_cmp++; if (hs.busy !== 1'b0 || hs.count !== 4'd0 || hs.out_valid !== 1'b0) begin
         n_err++; $display("FAIL full_end: got busy %b count %0d valid %b want 0 0 0", hs.busy, hs.count, hs.out_valid);
      end
   endtask

   task automatic test_early_flush;
      kv[0] = 100; kv[1] = -100;
      load_batch(2, 0, 1'b0);
      drain(2, 2, 0, 1'b0);
      n_cmp++; if (tmo || first_lat > 2) begin n_err++; $display("FAIL flush_lat: got %0d tmo %b want <=2", first_lat, tmo); end
      n_cmp++; if (got_q.size() != 2 || got_q[0] !== 32'hFFFFFF9C || got_q[1] !== 32'd100) begin
         n_err++; $display("FAIL flush_data: got %0d,%0d want -100,100", $signed(got_q[0]), $signed(got_q[1]));
      end
      n_cmp++; if (last_q.size() != 2 || last_q[0] !== 1'b0 || last_q[1] !== 1'b1) begin
         n_err++; $display("FAIL flush_last: got %b%b want 01", last_q[0], last_q[1]);
      end
      n_cmp++; if (hs.in_ready !== 1'b1 || hs.busy !== 1'b0) begin
         n_err++; $display("FAIL flush_idle: got ready %b busy %b want 1 0", hs.in_ready, hs.busy);
      end
   endtask

   task automatic test_single_key;
      kv[0] = 32'h8000_0000;
      load_batch(1, 1, 1'b0);
      n_cmp++; if (hs.out_valid !== 1'b1 || hs.out_data !== 32'h8000_0000 || hs.out_last !== 1'b1) begin
         n_err++; $display("FAIL single_out: got valid %b data %h last %b want 1 80000000 1", hs.out_valid, hs.out_data, hs.out_last);
      end
      drain(1, 1, 0, 1'b0);
      n_cmp++; if (tmo || hs.busy !== 1'b0 || hs.count !== 4'd0) begin
         n_err++; $display("FAIL single_end: got busy %b count %0d tmo %b want 0 0 0", hs.busy, hs.count, tmo);
      end
   endtask

   task automatic test_backpressure;
      kv[0] = 12; kv[1] = -7; kv[2] = 3; kv[3] = 3; kv[4] = -20; kv[5] = 8;
      es[0] = -20; es[1] = -7; es[2] = 3; es[3] = 3; es[4] = 8; es[5] = 12;
      load_batch(6, 2, 1'b0);
      drain(6, 6, 5, 1'b1);
      n_cmp++; if (tmo) begin n_err++; $display("FAIL bp_timeout: got %0d keys want 6", got_q.size()); end
      n_cmp++; if (unstable) begin n_err++; $display("FAIL bp_stable: output changed while stalled, want stable"); end
      n_cmp++; if (pop_bad) begin n_err++; $display("FAIL bp_pop_lat: pop latency outside 1..bound"); end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (i >= got_q.size() || got_q[i] !== es[i] || last_q[i] !== (i == 5)) begin
            n_err++; $display("FAIL bp_out[%0d]: got %0d last %b want %0d last %b", i, $signed(got_q[i]), last_q[i], $signed(es[i]), (i == 5));
         end
      end
   endtask

   task automatic test_reset_mid;
      kv[0] = 4; kv[1] = 8; kv[2] = 1; kv[3] = 7; kv[4] = 3; kv[5] = 6;
      load_batch(6, 2, 1'b0);
      drain(6, 2, 0, 1'b0);
      n_cmp++; if (got_q.size() != 2 || got_q[0] !== 32'd1 || got_q[1] !== 32'd3) begin
         n_err++; $display("FAIL mid_pops: got %0d,%0d want 1,3", $signed(got_q[0]), $signed(got_q[1]));
      end
      n_cmp++; if (hs.busy !== 1'b1 || hs.out_valid !== 1'b0 || hs.count !== 4'd4) begin
         n_err++; $display("FAIL mid_sift: got busy %b valid %b count %0d want 1 0 4", hs.busy, hs.out_valid, hs.count);
      end
      rstn = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (hs.in_ready !== 1'b0 || hs.out_valid !== 1'b0 || hs.out_last !== 1'b0 ||
          hs.out_data !== 32'h0 || hs.busy !== 1'b0 || hs.count !== 4'd0) begin
         n_err++; $display("FAIL mid_reset: got rdy %b vld %b last %b data %h busy %b cnt %0d want all 0",
                           hs.in_ready, hs.out_valid, hs.out_last, hs.out_data, hs.busy, hs.count);
      end
      rstn = 1'b1;
      @(negedge clk);
      kv[0] = 3; kv[1] = 2; kv[2] = 1;
      load_batch(3, 0, 1'b0);
      drain(3, 3, 0, 1'b0);
      n_cmp++; if (tmo || got_q.size() != 3 || got_q[0] !== 32'd1 || got_q[1] !== 32'd2 || got_q[2] !== 32'd3) begin
         n_err++; $display("FAIL mid_fresh: got %0d,%0d,%0d want 1,2,3", $signed(got_q[0]), $signed(got_q[1]), $signed(got_q[2]));
      end
   endtask

   task automatic test_random;
      int n, fm, blat;
      bit bad_d;
      for (int b = 0; b < 1000; b++) begin
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++)
            kv[i] = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 12)) - 32'd6;
         if (n == 1) fm = 1;
         else if (n == 6) fm = $urandom_range(0, 2);
         else fm = $urandom_range(0, 1);
         make_expected(n);
         blat = (n == 1) ? 0 : n * $clog2(n);
         load_batch(n, fm, 1'($urandom_range(0, 1)));
         drain(n, n, 0, 1'b1);
         n_cmp++; if (tmo || ready_bad) begin n_err++; $display("FAIL rnd_flow[%0d]: tmo %b ready_bad %b want 0 0", b, tmo, ready_bad); end
         n_cmp++; if (first_lat > blat || pop_bad) begin
            n_err++; $display("FAIL rnd_lat[%0d]: first %0d want <=%0d pop_bad %b", b, first_lat, blat, pop_bad);
         end
         bad_d = (got_q.size() != n);
         for (int i = 0; i < n && !bad_d; i++)
            if (got_q[i] !== es[i] || last_q[i] !== (i == n - 1)) bad_d = 1'b1;
         n_cmp++; if (bad_d) begin
            n_err++; $display("FAIL rnd_data[%0d]: n %0d got %0d keys first %0d want first %0d", b, n, got_q.size(), $signed(got_q[0]), $signed(es[0]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_batch();
      test_early_flush();
      test_single_key();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
